// File: rtl/dcs_bars.sv
// Colour-bar test-pattern source: DCS window header (2A/2B/2C) followed by W*H RGB565 pixels.
// Latency: first byte presented the cycle after start is sampled in IDLE; one byte per accepted get.
// Backpressure: pure pull source; byte held stable until get=1 while empty=0, never stalls mid-frame.
//
// Ports:
//   clock    system clock, all state on rising edge
//   reset_n  asynchronous active-low reset
//   start    frame request, only looked at in IDLE
//   dc       0 = command byte, 1 = parameter/pixel byte
//   data     current byte
//   get      consumer accepts the current byte this cycle
//   empty    no byte available (IDLE)
//   done     one-cycle pulse after the last byte of a frame is accepted
module dcs_bars #(
    parameter int W   = 240,
    parameter int H   = 240,
    parameter int BAR = 30
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic       dc,
    output logic [7:0] data,
    input  logic       get,
    output logic       empty,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAD  = 2'd1,
        PIXEL = 2'd2
    } state_t;

    localparam logic [15:0] W_M1   = 16'(W - 1);
    localparam logic [15:0] H_M1   = 16'(H - 1);
    localparam logic [8:0]  X_LAST = 9'(W - 1);
    localparam logic [8:0]  Y_LAST = 9'(H - 1);

    state_t      state, state_nx;
    logic [3:0]  hidx, hidx_nx;
    logic [8:0]  x, x_nx;
    logic [8:0]  y, y_nx;
    logic        phase, phase_nx;   // 0 = high byte of pixel, 1 = low byte
    logic        done_nx;
    logic        accept;

    logic [31:0] bar_full;
    logic [2:0]  bar;
    logic [15:0] colour;

    // Bar index saturates at 7 so pixels past the eighth bar stay black.
    always_comb begin
        bar_full = 32'(x) / 32'(BAR);
        bar      = (bar_full > 32'd7) ? 3'd7 : bar_full[2:0];
        case (bar)
            3'd0:    colour = 16'hFFFF;
            3'd1:    colour = 16'hFFE0;
            3'd2:    colour = 16'h07FF;
            3'd3:    colour = 16'h07E0;
            3'd4:    colour = 16'hF81F;
            3'd5:    colour = 16'hF800;
            3'd6:    colour = 16'h001F;
            default: colour = 16'h0000;
        endcase
    end

    // Outputs decode registered state only; get/start never reach them.
    always_comb begin
        empty = (state == IDLE);
        dc    = 1'b0;
        data  = 8'h00;
        case (state)
            HEAD: begin
                dc = !(hidx == 4'd0 || hidx == 4'd5 || hidx == 4'd10);
                case (hidx)
                    4'd0:    data = 8'h2A;
                    4'd3:    data = W_M1[15:8];
                    4'd4:    data = W_M1[7:0];
                    4'd5:    data = 8'h2B;
                    4'd8:    data = H_M1[15:8];
                    4'd9:    data = H_M1[7:0];
                    4'd10:   data = 8'h2C;
                    default: data = 8'h00;
                endcase
            end
            PIXEL: begin
                dc   = 1'b1;
                data = phase ? colour[7:0] : colour[15:8];
            end
            default: ;
        endcase
    end

    assign accept = get && !empty;

    always_comb begin
        state_nx = state;
        hidx_nx  = hidx;
        x_nx     = x;
        y_nx     = y;
        phase_nx = phase;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = HEAD;
                    hidx_nx  = 4'd0;
                end
            end
            HEAD: begin
                if (accept) begin
                    if (hidx == 4'd10) begin
                        state_nx = PIXEL;
                        x_nx     = 9'd0;
                        y_nx     = 9'd0;
                        phase_nx = 1'b0;
                    end else begin
                        hidx_nx = hidx + 4'd1;
                    end
                end
            end
            PIXEL: begin
                if (accept) begin
                    phase_nx = !phase;
                    // Counters only move once the low byte of a pixel is taken.
                    if (phase) begin
                        if (x == X_LAST) begin
                            x_nx = 9'd0;
                            if (y == Y_LAST) begin
                                y_nx     = 9'd0;
                                state_nx = IDLE;
                                done_nx  = 1'b1;
                            end else begin
                                y_nx = y + 9'd1;
                            end
                        end else begin
                            x_nx = x + 9'd1;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            hidx  <= 4'd0;
            x     <= 9'd0;
            y     <= 9'd0;
            phase <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            hidx  <= hidx_nx;
            x     <= x_nx;
            y     <= y_nx;
            phase <= phase_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_dcs_bars.sv
// Bench for dcs_bars: three instances (240x240/30, 20x4/2, 3x2/1) pulled through a byte scoreboard.
// Expected bytes come from an index-based model pushed when a frame is started.
// Outputs are sampled on the falling edge; inputs change on the falling edge or just after the rising edge.
module tb_dcs_bars;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start [3];
    logic       get   [3];
    logic       dc    [3];
    logic       empty [3];
    logic       done  [3];
    logic [7:0] data  [3];

    int pw [3] = '{240, 20, 3};
    int ph [3] = '{240, 4, 2};
    int pb [3] = '{30, 2, 1};

    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    dcs_bars u_a (
        .clock(clock), .reset_n(reset_n), .start(start[0]), .dc(dc[0]),
        .data(data[0]), .get(get[0]), .empty(empty[0]), .done(done[0])
    );

    dcs_bars #(.W(20), .H(4), .BAR(2)) u_b (
        .clock(clock), .reset_n(reset_n), .start(start[1]), .dc(dc[1]),
        .data(data[1]), .get(get[1]), .empty(empty[1]), .done(done[1])
    );

    dcs_bars #(.W(3), .H(2), .BAR(1)) u_c (
        .clock(clock), .reset_n(reset_n), .start(start[2]), .dc(dc[2]),
        .data(data[2]), .get(get[2]), .empty(empty[2]), .done(done[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {dc, data} of byte k of a frame with the given geometry.
    function automatic logic [8:0] model(input int k, input int w, input int h, input int bar);
        int p;
        int x;
        int b;
        logic [15:0] c;
        case (k)
            0:       return {1'b0, 8'h2A};
            1, 2:    return {1'b1, 8'h00};
            3:       return {1'b1, 8'((w - 1) >> 8)};
            4:       return {1'b1, 8'((w - 1) & 255)};
            5:       return {1'b0, 8'h2B};
            6, 7:    return {1'b1, 8'h00};
            8:       return {1'b1, 8'((h - 1) >> 8)};
            9:       return {1'b1, 8'((h - 1) & 255)};
            10:      return {1'b0, 8'h2C};
            default: begin
                p = (k - 11) / 2;
                x = p % w;
                b = x / bar;
                if (b > 7) b = 7;
                case (b)
                    0:       c = 16'hFFFF;
                    1:       c = 16'hFFE0;
                    2:       c = 16'h07FF;
                    3:       c = 16'h07E0;
                    4:       c = 16'hF81F;
                    5:       c = 16'hF800;
                    6:       c = 16'h001F;
                    default: c = 16'h0000;
                endcase
                return {1'b1, (((k - 11) % 2) == 0) ? c[15:8] : c[7:0]};
            end
        endcase
    endfunction

    task automatic push_frame(input int s, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(model(i, pw[s], ph[s], pb[s]));
    endtask

    task automatic start_frame(input int s, input int n);
        push_frame(s, n);
        @(negedge clock);
        start[s] = 1'b1;
        @(negedge clock);
        start[s] = 1'b0;
        check("first_byte_valid", 32'(empty[s]), 32'd0);
    endtask

    // Pull n bytes from instance s; optional random throttling of get.
    task automatic pull(input int s, input int n, input bit throttle, output int got_n, output int dn);
        int         cyc;
        bit         held;
        logic [8:0] prev;
        cyc   = 0;
        held  = 1'b0;
        prev  = '0;
        got_n = 0;
        dn    = 0;
        while (got_n < n && cyc < 4 * n + 20) begin
            @(negedge clock);
            cyc++;
            if (done[s]) dn++;
            if (held) check("stall_stable", 32'({dc[s], data[s]}), 32'(prev));
            get[s] = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (get[s] && !empty[s]) begin
                if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check($sformatf("byte%0d", got_n), 32'({dc[s], data[s]}), 32'(exp_q.pop_front()));
                got_n++;
            end
            held = !empty[s] && !get[s];
            prev = {dc[s], data[s]};
        end
        @(posedge clock);
        #1 get[s] = 1'b0;
        if (got_n < n) check("pull_timeout", 32'(got_n), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int dn;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            get[i]   = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("rst_empty", 32'(empty[0]), 32'd1);
        check("rst_done",  32'(done[0]),  32'd0);
        check("rst_data",  32'(data[0]),  32'h00);
        check("rst_dc",    32'(dc[0]),    32'd0);
        reset_n = 1'b1;

        // Idle: nothing offered, get pulses ignored.
        repeat (10) @(negedge clock);
        check("idle_empty", 32'(empty[0]), 32'd1);
        check("idle_done",  32'(done[0]),  32'd0);
        check("idle_data",  32'(data[0]),  32'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            get[0] = 1'b1;
            @(negedge clock);
            get[0] = 1'b0;
            check("idle_get_empty", 32'(empty[0]), 32'd1);
            check("idle_get_data",  32'(data[0]),  32'h00);
        end

        // 240x240: header + first two rows, start pulse at byte 500, reset at byte 1000.
        start_frame(0, 1000);
        pull(0, 500, 1'b0, g, dn);
        check("a_cnt500", 32'(g), 32'd500);
        @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        pull(0, 500, 1'b1, g, dn);
        check("a_cnt1000", 32'(g), 32'd500);
        check("a_no_done", 32'(dn), 32'd0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_empty", 32'(empty[0]), 32'd1);
        check("abort_data",  32'(data[0]),  32'h00);
        check("abort_dc",    32'(dc[0]),    32'd0);
        repeat (2) @(negedge clock);
        check("abort_done", 32'(done[0]), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_stays_idle", 32'(empty[0]), 32'd1);
        check("abort_done2", 32'(done[0]), 32'd0);
        check("sb_drained_a", 32'(exp_q.size()), 32'd0);
        start_frame(0, 11);
        pull(0, 11, 1'b0, g, dn);
        check("a_restart_hdr", 32'(g), 32'd11);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // 20x4/2: throttled full frame, bar saturation, single done pulse.
        start_frame(1, 11 + 2 * 20 * 4);
        pull(1, 11 + 2 * 20 * 4, 1'b1, g, dn);
        check("b_bytes", 32'(g), 32'd171);
        check("b_no_early_done", 32'(dn), 32'd0);
        @(negedge clock);
        check("b_done_pulse", 32'(done[1]),  32'd1);
        check("b_done_empty", 32'(empty[1]), 32'd1);
        @(negedge clock);
        check("b_done_low",  32'(done[1]),  32'd0);
        check("b_end_empty", 32'(empty[1]), 32'd1);

        // 3x2/1 with start held high: frame, done, then immediate restart.
        push_frame(2, 23);
        @(negedge clock);
        start[2] = 1'b1;
        @(negedge clock);
        check("c_first_valid", 32'(empty[2]), 32'd0);
        pull(2, 23, 1'b0, g, dn);
        check("c_bytes", 32'(g), 32'd23);
        @(negedge clock);
        check("c_done_pulse", 32'(done[2]),  32'd1);
        check("c_done_empty", 32'(empty[2]), 32'd1);
        @(negedge clock);
        check("c_restart_vld",  32'(empty[2]), 32'd0);
        check("c_restart_data", 32'(data[2]),  32'h2A);
        check("c_done_low",     32'(done[2]),  32'd0);
        start[2] = 1'b0;
        reset_n  = 1'b0;
        @(negedge clock);
        reset_n  = 1'b1;
        check("sb_drained_end", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcs_bars.md
DCS_BARS -- requirements
Module: dcs_bars

Interface
REQ-001 Parameters SHALL be, one per line:
  W  240  frame width in pixels, 1..512
  H  240  frame height in pixels, 1..512
  BAR  30  width of one colour bar in pixels, >= 1
REQ-002 Ports SHALL be, one per line:
  clock  in  1  single system clock; all state changes on its rising edge
  reset_n  in  1  asynchronous, active-low reset
  start  in  1  frame request, sampled only in IDLE
  dc  out  1  data/command flag of the current byte (0 = command, 1 = parameter/pixel)
  data  out  8  current DCS byte
  get  in  1  consumer pull: current byte accepted this cycle
  empty  out  1  no byte available
  done  out  1  one-cycle pulse after the last byte of a frame is accepted
REQ-003 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL act as a byte source for the DCS filter stage, with the same data/dc/get/empty pull handshake.

Function
REQ-005 States SHALL be IDLE, HEAD and PIXEL.
REQ-006 IDLE: empty=1; start=1 SHALL move the block to HEAD with the header index at 0, and the first byte SHALL be valid in the next cycle.
REQ-007 HEAD SHALL emit 11 bytes in this order: 2A, 00, 00, (W-1)[15:8], (W-1)[7:0], 2B, 00, 00, (H-1)[15:8], (H-1)[7:0], 2C.
REQ-008 In HEAD, dc SHALL be 0 at header indices 0, 5 and 10, and 1 at all other indices.
REQ-009 After header index 10 is accepted, the block SHALL enter PIXEL with x=0, y=0 and phase=high.
REQ-010 PIXEL SHALL emit each pixel as two bytes, RGB565 high byte then low byte, with dc=1.
REQ-011 Pixel colour SHALL be taken from bar index b = min(x / BAR, 7) using this table: 0 FFFF, 1 FFE0, 2 07FF, 3 07E0, 4 F81F, 5 F800, 6 001F, 7 0000.
REQ-012 Colour SHALL depend only on x, so every row is identical.
REQ-013 Counter advance order on an accepted low byte: x increments; at x=W-1, x wraps to 0 and y increments.
REQ-014 Counters x and y SHALL be 9 bits wide; the bar index SHALL saturate at 7 and never wrap.
REQ-015 When the low byte of pixel (W-1, H-1) is accepted, the block SHALL return to IDLE, assert empty the next cycle, and pulse done=1 for exactly one cycle.
REQ-016 Total bytes per frame SHALL be 11 + 2*W*H; for 240x240 this is 115211.
REQ-017 A byte SHALL be accepted only on a clock edge with get=1 and empty=0.
REQ-018 get=1 while empty=1 SHALL be ignored, with no state change.
REQ-019 While empty=0 and get=0, dc and data SHALL hold stable.
REQ-020 Outside IDLE, empty SHALL be 0 in every cycle; the source never stalls mid-frame.
REQ-021 start outside IDLE SHALL be ignored, including in the cycle the last byte is accepted.
REQ-022 A new frame SHALL need a fresh start sampled in IDLE; start held high SHALL restart one cycle after done.
REQ-023 Outputs SHALL depend only on registered state (no combinational path from get or start to any output).

Reset
REQ-024 While reset_n=0, the block SHALL be in IDLE with empty=1, done=0, dc=0, data=00, and header index, x, y and phase all at 0 / high.
REQ-025 Assertion of reset_n mid-frame SHALL abort the frame immediately with no done pulse; the next frame SHALL start only on a new start after release.

Verification
REQ-026 Reset, then 10 idle cycles -> empty=1, done=0, data=00; get pulses cause no change.
REQ-027 start, then pull continuously -> first 11 bytes 2A/00/00/00/EF/2B/00/00/00/EF/2C with dc 0,1,1,1,1,0,1,1,1,1,0.
REQ-028 Pixel stream check -> bytes 12..13 = FF,FF; pixel x=30 = FF,E0; x=210..239 = 00,00; row 1 pixel 0 = FF,FF.
REQ-029 Random get throttling over a full frame -> exactly 115211 bytes accepted, data stable during stalls, then a single done pulse, then empty=1.
REQ-030 start pulsed at byte 500, then reset_n low at byte 1000 -> start ignored; empty=1 immediately; no done pulse; a fresh start after release yields byte 2A.
REQ-031 Parameters W=3, H=2, BAR=1 -> 23 bytes; header bytes 3 and 4 = 00,02; bytes 8 and 9 = 00,01; pixel colours FFFF, FFE0, 07FF on each row.
